// File: rtl/adc_frame_receiver_pkg.sv
// Shared definitions for the ADC frame receiver: FSM states, default
// parameter values and a counter-width helper.
package adc_frame_receiver_pkg;

  localparam int DEF_WIDTH       = 13;
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_TRIG_PERIOD = 64;
  localparam int DEF_TIMEOUT     = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VALID = 2'd1,
    SHIFT      = 2'd2
  } state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_trigger_timer.sv
// Trigger period timer: free-running period counter plus the bookkeeping
// that defers a trigger while an unread word is still waiting.
module adc_trigger_timer
  import adc_frame_receiver_pkg::*;
#(
  parameter int TRIG_PERIOD = DEF_TRIG_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic idle_i,
  input  logic out_valid_i,
  output logic fire_o
);

  localparam int CW = cntWidth(TRIG_PERIOD);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          termCount;

  assign termCount = enable_i && (count_q == CW'(TRIG_PERIOD - 1));

  // A trigger goes out at terminal count, or later once a missed one can be served.
  assign fire_o = idle_i && !out_valid_i && enable_i && (termCount || pending_q);

  // Next-state for the period counter and the deferred-trigger flag.
  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    if (!enable_i || termCount) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
    if (fire_o) begin
      pending_d = 1'b0;
    end else if (termCount && idle_i && out_valid_i) begin
      pending_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/adc_frame_receiver.sv
// ADC frame receiver: requests frames from a serialiser, shifts in an
// MSB-first two's-complement word and presents it sign-extended with a
// valid/ready handshake. Timeout and mid-frame restart are flagged by pulses.
module adc_frame_receiver
  import adc_frame_receiver_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int TRIG_PERIOD = DEF_TRIG_PERIOD,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 serial_in,
  input  logic                 valid_in,
  output logic                 trigger_out,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 timeout_err,
  output logic                 frame_err
);

  localparam int BW = cntWidth(WIDTH);
  localparam int TW = cntWidth(TIMEOUT);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic [TW-1:0]        waitCnt_q, waitCnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 trig_q, trig_d;
  logic                 tErr_q, tErr_d;
  logic                 fErr_q, fErr_d;
  logic                 fire;
  logic                 isIdle;
  logic [WIDTH-1:0]     nextWord;

  assign isIdle   = (state_q == IDLE);
  assign nextWord = {shift_q[WIDTH-2:0], serial_in};

  adc_trigger_timer #(
    .TRIG_PERIOD(TRIG_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .idle_i     (isIdle),
    .out_valid_i(valid_q),
    .fire_o     (fire)
  );

  // Frame FSM: wait for the serialiser, shift the word in, hand it over.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    waitCnt_d = waitCnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    trig_d    = 1'b0;
    tErr_d    = 1'b0;
    fErr_d    = 1'b0;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (fire) begin
          trig_d    = 1'b1;
          waitCnt_d = '0;
          state_d   = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        if (valid_in) begin
          shift_d  = WIDTH'(serial_in);
          bitCnt_d = BW'(WIDTH - 1);
          state_d  = SHIFT;
        end else if (waitCnt_q == TW'(TIMEOUT - 1)) begin
          tErr_d    = 1'b1;
          waitCnt_d = '0;
          state_d   = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + TW'(1);
        end
      end
      SHIFT: begin
        if (valid_in) begin
          fErr_d   = 1'b1;
          shift_d  = WIDTH'(serial_in);
          bitCnt_d = BW'(WIDTH - 1);
        end else begin
          shift_d  = nextWord;
          bitCnt_d = bitCnt_q - BW'(1);
          if (bitCnt_q == BW'(1)) begin
            data_d  = OUT_WIDTH'($signed(nextWord));
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      waitCnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      trig_q    <= 1'b0;
      tErr_q    <= 1'b0;
      fErr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      waitCnt_q <= waitCnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      trig_q    <= trig_d;
      tErr_q    <= tErr_d;
      fErr_q    <= fErr_d;
    end
  end

  assign trigger_out = trig_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign timeout_err = tErr_q;
  assign frame_err   = fErr_q;

endmodule

// File: tb/tb_adc_frame_receiver.sv
// Testbench for adc_frame_receiver: a serialiser model answers triggers,
// expected words go into a scoreboard queue, and a monitor compares what
// the receiver presents.
module tb_adc_frame_receiver;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        serial_in;
  logic        valid_in;
  logic        trigger_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;
  logic        frame_err;

  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  int   trigCount = 0;
  int   feCount = 0;
  int   toCount = 0;
  int   expFerr = 0;
  int   expTo = 0;
  exp_t sbQ[$];

  adc_frame_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .serial_in  (serial_in),
    .valid_in   (valid_in),
    .trigger_out(trigger_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .timeout_err(timeout_err),
    .frame_err  (frame_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle index used to timestamp triggers and expected word arrival.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Received word as a signed 13-bit value, re-expressed in 16 bits.
  function automatic logic [15:0] modelWord(input logic [12:0] w);
    int v;
    v = int'(w);
    if (v >= 4096) v = v - 8192;
    return 16'(v);
  endfunction

  // Scoreboard monitor: arrival latency, hold stability, data on handshake, pulse counts.
  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic        prevTrig = 1'b0;
  logic [15:0] prevData = '0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevTrig  = 1'b0;
    end else begin
      if (trigger_out) begin
        checkOutput("trigger_single_cycle", 32'(prevTrig), 32'd0);
        trigCount++;
      end
      if (timeout_err) toCount++;
      if (frame_err) feCount++;
      if (prevValid && !prevReady) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(prevData));
      end
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word (cycle %0d)", out_data, cyc);
        end else begin
          if (!prevValid) checkOutput("valid_latency", 32'(cyc), 32'(sbQ[0].cyc));
          if (out_ready) begin
            checkOutput("out_data", 32'(out_data), 32'(sbQ[0].data));
            void'(sbQ.pop_front());
          end
        end
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevData  = out_data;
      prevTrig  = trigger_out;
    end
  end

  task automatic waitTrigger(input int expCyc, input int budget, output bit found, output int tCyc);
    found = 1'b0;
    tCyc  = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (trigger_out) begin
        found = 1'b1;
        tCyc  = cyc;
      end
    end
    if (!found) begin
      compared++;
      failed++;
      $display("[TB] FAIL trigger_wait: no trigger_out within %0d cycles, expected one (cycle %0d)", budget, cyc);
    end else if (expCyc >= 0) begin
      checkOutput("trigger_cycle", 32'(tCyc), 32'(expCyc));
    end
  endtask

  // Serialiser model: optional aborted prefix of restartAt bits, then a full frame.
  task automatic applyStimulus(input logic [12:0] word, input int delay, input int restartAt,
                               input logic [12:0] junk);
    repeat (delay) @(negedge clk);
    if (restartAt > 0) begin
      for (int b = 0; b < restartAt; b++) begin
        valid_in  = (b == 0);
        serial_in = junk[12-b];
        @(negedge clk);
      end
      expFerr++;
    end
    for (int b = 0; b < 13; b++) begin
      valid_in  = (b == 0);
      serial_in = word[12-b];
      if (b == 12) sbQ.push_back('{modelWord(word), cyc + 1});
      @(negedge clk);
    end
    valid_in  = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic spuriousValid();
    valid_in  = 1'b1;
    serial_in = 1'($urandom);
    @(negedge clk);
    serial_in = 1'($urandom);
    @(negedge clk);
    valid_in  = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic doTimeout();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput("timeout_err_pulse", 32'(timeout_err), 32'(i == 8));
    end
    checkOutput("timeout_no_valid", 32'(out_valid), 32'd0);
    expTo++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_trigger_out"}, 32'(trigger_out), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  task automatic runTests();
    bit          found;
    int          t;
    int          nextExp;
    int          c;
    int          r;
    int          d;
    logic [12:0] w;

    enable    = 1'b0;
    valid_in  = 1'b0;
    serial_in = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    enable  = 1'b1;
    rst_n   = 1'b1;
    nextExp = cyc + 64;

    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    applyStimulus(13'h0123, 2, 0, '0);
    nextExp = t + 64;

    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    applyStimulus(13'h1F00, 0, 0, '0);
    nextExp = t + 64;

    c = feCount;
    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    applyStimulus(13'h0AAA, 1, 5, 13'h1555);
    checkOutput("frame_err_once", 32'(feCount - c), 32'd1);
    nextExp = t + 64;

    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    doTimeout();
    nextExp = t + 64;

    out_ready = 1'b0;
    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    applyStimulus(13'h0555, 3, 0, '0);
    c = trigCount;
    repeat (140) @(negedge clk);
    checkOutput("deferred_no_trigger", 32'(trigCount), 32'(c));
    checkOutput("deferred_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("deferred_hold_data", 32'(out_data), 32'h0555);
    out_ready = 1'b1;
    waitTrigger(cyc + 2, 5, found, t);
    if (!found) return;
    applyStimulus(13'($urandom), 1, 0, '0);
    nextExp = -1;

    for (int k = 0; k < 25; k++) begin
      waitTrigger(nextExp, 80, found, t);
      if (!found) return;
      w = 13'($urandom);
      d = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        doTimeout();
        nextExp = t + 64;
      end else if (r <= 2) begin
        applyStimulus(w, d, $urandom_range(1, 12), 13'($urandom));
        spuriousValid();
        nextExp = t + 64;
      end else if (r == 3) begin
        enable = 1'b0;
        applyStimulus(w, d, 0, '0);
        spuriousValid();
        enable  = 1'b1;
        nextExp = cyc + 64;
      end else begin
        applyStimulus(w, d, 0, '0);
        spuriousValid();
        nextExp = t + 64;
      end
    end

    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      valid_in  = (b == 0);
      serial_in = 1'b1;
      @(negedge clk);
    end
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    checkAllZero("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    nextExp = cyc + 64;
    waitTrigger(nextExp, 80, found, t);
    if (!found) return;
    applyStimulus(13'h1ABC, 4, 0, '0);
    repeat (4) @(negedge clk);
  endtask

  // Main sequence followed by end-of-run totals and the summary line.
  initial begin
    runTests();
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("frame_err_count", 32'(feCount), 32'(expFerr));
    checkOutput("timeout_count", 32'(toCount), 32'(expTo));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
